// File: rtl/block_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : block_update_scheduler_if
// Brief    : Processor-side request bus into the playfield write scheduler.
// Revision : 1.0
// ============================================================================
interface block_update_scheduler_if;
  logic       req_valid;
  logic [7:0] req_idx;
  logic [1:0] req_type;
  logic       req_ready;
  logic       clr_all;
`ifdef BLKSCHED_ROWCLR_EN
  logic       row_clr_valid;
  logic [4:0] row_clr_row;
  logic       row_clr_ready;

  modport master (
    output req_valid, req_idx, req_type, clr_all, row_clr_valid, row_clr_row,
    input  req_ready, row_clr_ready
  );
  modport slave (
    input  req_valid, req_idx, req_type, clr_all, row_clr_valid, row_clr_row,
    output req_ready, row_clr_ready
  );
`else
  modport master (
    output req_valid, req_idx, req_type, clr_all,
    input  req_ready
  );
  modport slave (
    input  req_valid, req_idx, req_type, clr_all,
    output req_ready
  );
`endif
endinterface
`default_nettype wire

// File: rtl/block_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : block_update_scheduler
// Brief    : Buffers playfield writes and commits them during vertical blanking.
//            Optional row-clear support under macro BLKSCHED_ROWCLR_EN.
// Revision : 1.0
// ============================================================================
module block_update_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_BLOCKS = 200,
  parameter int ROW_W      = 10
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        iVS,
  input  logic                        iBLANK_n,
  block_update_scheduler_if.slave     bus,
  output logic                        oWREN,
  output logic [7:0]                  oWADDR,
  output logic [1:0]                  oWDATA,
  output logic                        oBUSY,
  output logic [$clog2(FIFO_DEPTH):0] oFIFO_LVL,
  output logic                        oERR,
  output logic [15:0]                 oFRAME_CNT
);

  localparam int         c_AW       = $clog2(FIFO_DEPTH);
  localparam int         c_KW       = $clog2(ROW_W);
  localparam logic [7:0] c_LAST_BLK = 8'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CLEAR_ALL = 2'd1,
    S_DRAIN     = 2'd2
`ifdef BLKSCHED_ROWCLR_EN
   ,S_ROW_CLR   = 2'd3
`endif
  } state_t;

  state_t r_state, w_next, w_sel;

  // ---------------- blanking window ----------------
  logic r_vs, r_win;
  logic w_vs_fall, w_active;

  assign w_vs_fall = r_vs & ~iVS;
  assign w_active  = r_win & ~iBLANK_n;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_vs       <= 1'b0;
      r_win      <= 1'b0;
      oFRAME_CNT <= 16'd0;
    end else begin
      r_vs <= iVS;
      if (w_vs_fall) begin
        r_win      <= 1'b1;
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      end else if (iBLANK_n) begin
        r_win <= 1'b0;
      end
    end
  end

  // ---------------- request FIFO ----------------
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wp, r_rp, w_lvl;
  logic          w_empty, w_full, w_accept, w_in_range, w_push, w_pop;
  logic [9:0]    w_head;

  assign w_lvl      = r_wp - r_rp;
  assign w_empty    = (r_wp == r_rp);
  assign w_full     = (w_lvl == (c_AW+1)'(FIFO_DEPTH));
  assign w_accept   = bus.req_valid & ~w_full;
  assign w_in_range = ({1'b0, bus.req_idx} < 9'(NUM_BLOCKS));
  assign w_push     = w_accept & w_in_range;
  assign w_head     = r_mem[r_rp[c_AW-1:0]];
  assign bus.req_ready = ~w_full;
  assign oFIFO_LVL     = w_lvl;

  always_ff @(posedge iVGA_CLK) begin
    if (w_push) r_mem[r_wp[c_AW-1:0]] <= {bus.req_idx, bus.req_type};
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (c_AW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (c_AW+1)'(1);
    end
  end

  // ---------------- clear-all bookkeeping ----------------
  logic       r_clr_pend;
  logic [7:0] r_clr_cnt;
  logic       w_clr_inc, w_clr_done;

  // A pulse while pending is a no-op; completion wins over a coincident pulse.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clr_pend <= 1'b0;
      r_clr_cnt  <= 8'd0;
    end else if (w_clr_done) begin
      r_clr_pend <= 1'b0;
      r_clr_cnt  <= 8'd0;
    end else begin
      if (bus.clr_all) r_clr_pend <= 1'b1;
      if (w_clr_inc)   r_clr_cnt  <= r_clr_cnt + 8'd1;
    end
  end

  // ---------------- row-clear bookkeeping ----------------
  logic w_row_bad;
  logic w_row_pend;
`ifdef BLKSCHED_ROWCLR_EN
  logic            r_row_pend;
  logic [4:0]      r_row;
  logic [c_KW-1:0] r_row_k;
  logic            w_row_acc, w_row_inc, w_row_done;
  logic [7:0]      w_row_addr;

  assign w_row_acc  = bus.row_clr_valid & ~r_row_pend;
  assign w_row_bad  = w_row_acc & (bus.row_clr_row >= 5'(NUM_BLOCKS / ROW_W));
  assign w_row_addr = 8'((32'(r_row) * ROW_W) + 32'(r_row_k));
  assign w_row_pend = r_row_pend;
  assign bus.row_clr_ready = ~r_row_pend;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_row_pend <= 1'b0;
      r_row      <= 5'd0;
      r_row_k    <= '0;
    end else if (w_row_done) begin
      r_row_pend <= 1'b0;
      r_row_k    <= '0;
    end else begin
      if (w_row_acc && !w_row_bad) begin
        r_row_pend <= 1'b1;
        r_row      <= bus.row_clr_row;
      end
      if (w_row_inc) r_row_k <= r_row_k + c_KW'(1);
    end
  end
`else
  assign w_row_bad  = 1'b0;
  assign w_row_pend = 1'b0;
`endif

  // ---------------- FSM ----------------
  logic       w_wr;
  logic [7:0] w_addr;
  logic [1:0] w_data;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // The dispatch decision and the first write share a cycle, so work states
  // chain back-to-back without an idle bubble.
  always_comb begin
    w_next     = S_IDLE;
    w_sel      = S_IDLE;
    w_wr       = 1'b0;
    w_addr     = 8'd0;
    w_data     = 2'b00;
    w_pop      = 1'b0;
    w_clr_inc  = 1'b0;
    w_clr_done = 1'b0;
`ifdef BLKSCHED_ROWCLR_EN
    w_row_inc  = 1'b0;
    w_row_done = 1'b0;
`endif
    if (w_active) begin
      w_sel = r_state;
      if (r_state == S_IDLE || (r_state == S_DRAIN && w_empty)) begin
        if (r_clr_pend)      w_sel = S_CLEAR_ALL;
`ifdef BLKSCHED_ROWCLR_EN
        else if (r_row_pend) w_sel = S_ROW_CLR;
`endif
        else if (!w_empty)   w_sel = S_DRAIN;
        else                 w_sel = S_IDLE;
      end
      case (w_sel)
        S_CLEAR_ALL: begin
          w_wr   = 1'b1;
          w_addr = r_clr_cnt;
          if (r_clr_cnt == c_LAST_BLK) begin
            w_clr_done = 1'b1;
            w_next     = S_IDLE;
          end else begin
            w_clr_inc = 1'b1;
            w_next    = S_CLEAR_ALL;
          end
        end
`ifdef BLKSCHED_ROWCLR_EN
        S_ROW_CLR: begin
          w_wr   = 1'b1;
          w_addr = w_row_addr;
          if (r_row_k == c_KW'(ROW_W - 1)) begin
            w_row_done = 1'b1;
            w_next     = S_IDLE;
          end else begin
            w_row_inc = 1'b1;
            w_next    = S_ROW_CLR;
          end
        end
`endif
        S_DRAIN: begin
          w_wr             = 1'b1;
          w_pop            = 1'b1;
          {w_addr, w_data} = w_head;
          w_next           = S_DRAIN;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oWREN  <= 1'b0;
      oWADDR <= 8'd0;
      oWDATA <= 2'b00;
      oERR   <= 1'b0;
    end else begin
      oWREN <= w_wr;
      if (w_wr) begin
        oWADDR <= w_addr;
        oWDATA <= w_data;
      end
      if ((w_accept && !w_in_range) || w_row_bad) oERR <= 1'b1;
    end
  end

  assign oBUSY = (r_state != S_IDLE) | r_clr_pend | w_row_pend | ~w_empty;

endmodule
`default_nettype wire

// File: doc/block_update_scheduler.md
# block_update_scheduler

Sequences all writes into the 200-entry (10 columns × 20 rows) playfield block RAM that the VGA controller scans for display. Processor write requests are buffered in a small FIFO and committed only during vertical blanking, so a frame is never drawn half-updated. Clear-all and row-clear commands are also scheduled. The block sits between the processor interface and the block RAM write port, in the iVGA_CLK domain.

## Interface

Parameters:
- FIFO_DEPTH, 8: request FIFO entries; must be a power of two, ≥2.
- NUM_BLOCKS, 200: playfield entries; valid indices are 0..NUM_BLOCKS-1.
- ROW_W, 10: blocks per row.

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on its rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- iVS  in  1  active-low vertical sync from the sync generator.
- iBLANK_n  in  1  active-high display-enable from the sync generator.
- req_valid  in  1  processor write request.
- req_idx  in  8  target block index.
- req_type  in  2  block value (00 none, 01 occupied, 11 stuck).
- req_ready  out  1  equals ~FIFO full; a request is accepted when req_valid && req_ready.
- clr_all  in  1  single-cycle pulse: zero all NUM_BLOCKS entries.
- row_clr_valid  in  1  row-clear request (only with BLKSCHED_ROWCLR_EN).
- row_clr_row  in  5  row 0..19 (only with BLKSCHED_ROWCLR_EN).
- row_clr_ready  out  1  high when no row clear is pending (only with BLKSCHED_ROWCLR_EN).
- oWREN  out  1  block RAM write enable, registered.
- oWADDR  out  8  block RAM write address, registered.
- oWDATA  out  2  block RAM write data, registered.
- oBUSY  out  1  high when the FSM is not IDLE, or any work is pending.
- oFIFO_LVL  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- oERR  out  1  sticky flag: an out-of-range index was dropped.
- oFRAME_CNT  out  16  count of blanking windows opened; wraps at 0xFFFF→0.

## Operation

- **Blanking window.**
  - iVS is registered once.
  - The window opens on the cycle after a registered high→low transition of iVS.
  - The window closes on the first cycle iBLANK_n is sampled high.
  - oWREN asserts only while the window is open.
- **Enqueue.**
  - On an accepted request, {req_idx, req_type} is pushed.
  - If req_idx ≥ NUM_BLOCKS, the request is still accepted (handshake completes) but is not pushed, and oERR is set.
- **FSM states:** IDLE, CLEAR_ALL, ROW_CLR, DRAIN.
- **IDLE.** On window open, the priority is:
  1. clear pending → CLEAR_ALL.
  2. Else row clear pending → ROW_CLR.
  3. Else FIFO non-empty → DRAIN.
  4. Else stay in IDLE.
- **CLEAR_ALL.**
  - Writes address clr_cnt with data 00, one per cycle; clr_cnt runs 0..NUM_BLOCKS-1.
  - After the last write, the clear-pending flag is cleared and the FSM applies the IDLE priority again within the same window.
- **ROW_CLR.**
  - Writes row*ROW_W + k with data 00, for k = 0..ROW_W-1.
  - Then releases the pending flag.
- **DRAIN.**
  - Pops one entry per cycle and writes it.
  - Goes to IDLE when the FIFO is empty.
- **Window close in any state.**
  - The FSM goes to IDLE; oWREN is deasserted that same cycle.
  - clr_cnt and the row counter are held.
  - The interrupted operation resumes at the next window at the same counter value.
- **clr_all pulses.**
  - While a clear is pending or executing, further pulses are absorbed (no restart).
  - Queued FIFO entries are not discarded; they are written after the clear completes.
- **Simultaneous push and pop.** Both occur; oFIFO_LVL is unchanged.
- **Full FIFO.** req_ready=0; req_valid is ignored.
- **Reset** (async, effective immediately):
  - FIFO emptied, FSM in IDLE, all counters and pending flags zeroed.
  - oWREN=0, oWADDR=0, oWDATA=0, oBUSY=0, oFIFO_LVL=0, oERR=0, oFRAME_CNT=0.
  - req_ready=1 and row_clr_ready=1.

## Timing

- A window opens at cycle N (the cycle after the iVS falling edge is seen in the register). Entry into the first work state occurs at N; the first oWREN appears at N+1.
- Sustained throughput is one write per cycle, with no bubbles between CLEAR_ALL, ROW_CLR and DRAIN.
- Enqueue-to-visibility: an entry accepted at cycle M is written in the first window opening after M+1.
- oFRAME_CNT increments in the cycle the window opens.
- With 640×480 timing, a blanking window of roughly 35 lines × 800 clocks always covers a full clear (200 writes) plus FIFO_DEPTH writes. The resume path exists only to keep correctness for short windows and for entry mid-window.

## Configuration

- **BLKSCHED_ROWCLR_EN defined:** the ROW_CLR state, the row_clr_* ports and a single-entry row pending register are present.
  - The handshake is row_clr_valid && row_clr_ready.
  - row_clr_row ≥ 20 is accepted, dropped, and sets oERR.
- **BLKSCHED_ROWCLR_EN undefined:**
  - The row_clr_* ports are absent and the ROW_CLR state is not generated.
  - The FSM goes IDLE → CLEAR_ALL → DRAIN only.

## Test plan

- Push idx 5/type 01, idx 199/type 11, idx 0/type 01 mid-frame → no oWREN until the window opens; then three consecutive writes (5,01), (199,11), (0,01); oFIFO_LVL goes 3→0.
- Push FIFO_DEPTH+2 requests back-to-back with no window → req_ready drops after 8 are accepted; the 2 extra requests are held off; oFIFO_LVL=8.
- clr_all pulse, then push idx 7/type 01 → next window writes 200 zeros at addresses 0..199, then (7,01); oBUSY falls afterwards.
- clr_all pulse; force iBLANK_n high after 50 clear writes → oWREN drops that cycle; the next window resumes at address 50 and finishes at 199.
- req_idx=200 → handshake completes, oERR=1, nothing is written; oERR stays set until reset.
- With BLKSCHED_ROWCLR_EN defined: row clear of row 19 plus one queued entry → writes addresses 190..199 with 00, then the queued entry. Assert iRST_n low mid-row → outputs go to 0 at once and no writes occur after release.
